// File: rtl/wt_mem_req_arbiter_if.sv
// Bundle of every signal between the N client ports, the arbiter and the
// single memory adapter, apart from clock and reset.
//   slave  : arbiter side (takes client requests and adapter returns)
//   master : environment side (clients + adapter driving the arbiter)
// Client vectors are packed per port: port k at [k*W +: W].
// mem_tid_o and mem_rtrn_tid_i carry {port index, client tid}.
interface wt_mem_req_arbiter_if #(
    parameter int unsigned NumPorts     = 2,
    parameter int unsigned PayloadWidth = 128,
    parameter int unsigned TidWidth     = 2,
    parameter int unsigned RtrnWidth    = 128
);
    localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic                             stall_i;
    logic                             busy_o;
    logic                             error_o;
    logic [NumPorts-1:0]              req_i;
    logic [NumPorts*PayloadWidth-1:0] payload_i;
    logic [NumPorts*TidWidth-1:0]     tid_i;
    logic [NumPorts-1:0]              ack_o;
    logic                             mem_req_o;
    logic [PayloadWidth-1:0]          mem_payload_o;
    logic [TidWidth+PW-1:0]           mem_tid_o;
    logic                             mem_ack_i;
    logic                             mem_rtrn_vld_i;
    logic [TidWidth+PW-1:0]           mem_rtrn_tid_i;
    logic [RtrnWidth-1:0]             mem_rtrn_data_i;
    logic [NumPorts-1:0]              rtrn_vld_o;
    logic [TidWidth-1:0]              rtrn_tid_o;
    logic [RtrnWidth-1:0]             rtrn_data_o;

    modport slave (
        input  stall_i, req_i, payload_i, tid_i, mem_ack_i,
               mem_rtrn_vld_i, mem_rtrn_tid_i, mem_rtrn_data_i,
        output busy_o, error_o, ack_o, mem_req_o, mem_payload_o, mem_tid_o,
               rtrn_vld_o, rtrn_tid_o, rtrn_data_o
    );

    modport master (
        output stall_i, req_i, payload_i, tid_i, mem_ack_i,
               mem_rtrn_vld_i, mem_rtrn_tid_i, mem_rtrn_data_i,
        input  busy_o, error_o, ack_o, mem_req_o, mem_payload_o, mem_tid_o,
               rtrn_vld_o, rtrn_tid_o, rtrn_data_o
    );
endinterface

// File: rtl/wt_mem_req_arbiter.sv
// N-client memory request arbiter in front of the single memory adapter.
// Picks one eligible client (round-robin or fixed priority), presents its
// payload to the adapter until accepted, tracks per-port outstanding credits
// and routes returns back by the port prefix of the transaction ID.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : client / adapter signal bundle (slave modport)
//
// state | meaning
// IDLE  | no grant held; arbitrate among eligible ports unless stalled
// GRANT | port gnt_q presented to adapter, waiting for mem_ack_i
module wt_mem_req_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned PayloadWidth   = 128,
    parameter int unsigned TidWidth       = 2,
    parameter int unsigned RtrnWidth      = 128,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned ArbMode        = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    wt_mem_req_arbiter_if.slave    bus
);
    localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           gnt_q, gnt_d;
    logic [PW-1:0]           rr_q, rr_d;
    logic [CW-1:0]           cnt_q [NumPorts];
    logic [CW-1:0]           cnt_d [NumPorts];
    logic                    error_q;

    logic [NumPorts-1:0]     elig, zero, hit, ack;
    logic [PW-1:0]           win;
    logic                    win_vld;
    logic                    ack_fire;
    logic                    err_set;
    logic [PW-1:0]           rtrn_port;
    logic [PayloadWidth-1:0] sel_payload;
    logic [TidWidth-1:0]     sel_tid;

    // Arbitration only sees registered credits, so a return frees a slot
    // for selection one cycle later.
    always_comb begin
        for (int k = 0; k < NumPorts; k++) begin
            zero[k] = (cnt_q[k] == '0);
            elig[k] = bus.req_i[k] && (cnt_q[k] < CW'(MaxOutstanding));
        end
    end

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        if (ArbMode == 1) begin
            for (int k = NumPorts - 1; k >= 0; k--) begin
                if (elig[k]) begin
                    win     = PW'(k);
                    win_vld = 1'b1;
                end
            end
        end else begin
            // First pass: lowest eligible index at or after rr_q.
            // Second pass: wrap around to the lowest eligible index overall.
            for (int k = 0; k < NumPorts; k++) begin
                if (!win_vld && elig[k] && (PW'(k) >= rr_q)) begin
                    win     = PW'(k);
                    win_vld = 1'b1;
                end
            end
            for (int k = 0; k < NumPorts; k++) begin
                if (!win_vld && elig[k]) begin
                    win     = PW'(k);
                    win_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        ack_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.stall_i && win_vld) begin
                    gnt_d   = win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // stall_i is deliberately ignored here: a grant in flight completes.
                if (bus.mem_ack_i) begin
                    ack_fire = 1'b1;
                    state_d  = IDLE;
                    rr_d     = (gnt_q == PW'(NumPorts - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_payload = '0;
        sel_tid     = '0;
        for (int k = 0; k < NumPorts; k++) begin
            ack[k] = ack_fire && (gnt_q == PW'(k));
            if (gnt_q == PW'(k)) begin
                sel_payload = bus.payload_i[k*PayloadWidth +: PayloadWidth];
                sel_tid     = bus.tid_i[k*TidWidth +: TidWidth];
            end
        end
    end

    assign bus.mem_req_o     = (state_q == GRANT);
    assign bus.mem_payload_o = (state_q == GRANT) ? sel_payload : '0;
    assign bus.mem_tid_o     = (state_q == GRANT) ? {gnt_q, sel_tid} : '0;
    assign bus.ack_o         = ack;

    // A prefix that matches no port leaves hit all-zero: the return is dropped.
    // A return to a port with no credit is still delivered but flagged.
    assign rtrn_port = bus.mem_rtrn_tid_i[TidWidth +: PW];

    always_comb begin
        for (int k = 0; k < NumPorts; k++) begin
            hit[k] = bus.mem_rtrn_vld_i && (rtrn_port == PW'(k));
            cnt_d[k] = cnt_q[k];
            case ({ack[k], hit[k] & ~zero[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + 1'b1;
                2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    assign err_set = bus.mem_rtrn_vld_i && ((hit == '0) || ((hit & zero) != '0));

    assign bus.rtrn_vld_o  = hit;
    assign bus.rtrn_tid_o  = bus.mem_rtrn_tid_i[TidWidth-1:0];
    assign bus.rtrn_data_o = bus.mem_rtrn_data_i;
    assign bus.busy_o      = (state_q == GRANT) || (zero != {NumPorts{1'b1}});
    assign bus.error_o     = error_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            error_q <= 1'b0;
            for (int k = 0; k < NumPorts; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            error_q <= error_q | err_set;
            for (int k = 0; k < NumPorts; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end
endmodule
